// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-extension stage: mode encodings and
// the skid-buffer occupancy states.
package imm_pkg;

    // Extension modes as carried on the 2-bit mode field from decode.
    typedef enum logic [1:0] {
        IMM_SEXT   = 2'b00,
        IMM_ZEXT   = 2'b01,
        IMM_BRANCH = 2'b10,
        IMM_UPPER  = 2'b11
    } imm_mode_t;

    // Buffer occupancy, encoded directly as {skid_v, main_v}.
    // 2'b10 cannot occur because SKID only fills while MAIN is occupied.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } imm_state_t;

endpackage : imm_pkg

// File: rtl/imm_ext_core.sv
// Purely combinational immediate widener. Shared between the registered
// extension stage and the decode-stage bypass path, so it holds no state.
module imm_ext_core
    import imm_pkg::*;
#(
    parameter int IN_W     = 7,
    parameter int OUT_W    = 16,
    parameter int BR_SHIFT = 1
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] ext
);

    localparam int FILL_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext_val;
    logic [OUT_W-1:0] zext_val;
    logic [OUT_W-1:0] branch_val;
    logic [OUT_W-1:0] upper_val;

    // The four candidate results; branch reuses the sign-extended value and
    // simply drops anything shifted past the MSB.
    always_comb begin
        sext_val   = {{FILL_W{imm[IN_W-1]}}, imm};
        zext_val   = {{FILL_W{1'b0}}, imm};
        branch_val = sext_val << BR_SHIFT;
        upper_val  = {imm, {FILL_W{1'b0}}};
    end

    // Select the requested extension.
    always_comb begin
        ext = sext_val;
        case (imm_mode_t'(mode))
            IMM_SEXT:   ext = sext_val;
            IMM_ZEXT:   ext = zext_val;
            IMM_BRANCH: ext = branch_val;
            IMM_UPPER:  ext = upper_val;
            default:    ext = sext_val;
        endcase
    end

endmodule : imm_ext_core

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage between decode and the ALU operand
// mux. A two-entry skid buffer (MAIN feeds the outputs, SKID catches the
// overflow) keeps in_ready a pure register output, so back-pressure from
// execute never ripples combinationally back into decode.
module imm_extend_stage
    import imm_pkg::*;
#(
    parameter int IN_W     = 7,
    parameter int OUT_W    = 16,
    parameter int BR_SHIFT = 1,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    logic [OUT_W-1:0] ext_data;

    logic             main_v_q,    main_v_d;
    logic             skid_v_q,    skid_v_d;
    logic [OUT_W-1:0] main_data_q, main_data_d;
    logic [TAG_W-1:0] main_tag_q,  main_tag_d;
    logic [OUT_W-1:0] skid_data_q, skid_data_d;
    logic [TAG_W-1:0] skid_tag_q,  skid_tag_d;

    logic       accept;
    logic       pop;
    imm_state_t state;

    imm_ext_core #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_ext_core (
        .imm  (in_imm),
        .mode (in_mode),
        .ext  (ext_data)
    );

    assign state     = imm_state_t'({skid_v_q, main_v_q});
    assign in_ready  = !skid_v_q;
    assign out_valid = main_v_q;
    assign out_data  = main_data_q;
    assign out_tag   = main_tag_q;
    assign accept    = in_valid && in_ready;
    assign pop       = main_v_q && out_ready;

    // Next-state for the skid buffer: route new results to MAIN or SKID and
    // promote SKID into MAIN when the downstream drains the head entry.
    always_comb begin
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_data_d = main_data_q;
        main_tag_d  = main_tag_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    main_v_d    = 1'b1;
                    main_data_d = ext_data;
                    main_tag_d  = in_tag;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    main_data_d = ext_data;
                    main_tag_d  = in_tag;
                end else if (accept) begin
                    skid_v_d    = 1'b1;
                    skid_data_d = ext_data;
                    skid_tag_d  = in_tag;
                end else if (pop) begin
                    main_v_d = 1'b0;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    skid_v_d    = 1'b0;
                    main_data_d = skid_data_q;
                    main_tag_d  = skid_tag_q;
                end
            end
            default: begin
                main_v_d = 1'b0;
                skid_v_d = 1'b0;
            end
        endcase
    end

    // Buffer registers; reset drops any in-flight entries and clears the
    // visible outputs immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            main_data_q <= '0;
            main_tag_q  <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else begin
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            main_data_q <= main_data_d;
            main_tag_q  <= main_tag_d;
            skid_data_q <= skid_data_d;
            skid_tag_q  <= skid_tag_d;
        end
    end

endmodule : imm_extend_stage

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage: directed mode sweep, back-pressure,
// streaming with random stimulus, asynchronous reset and a wide-parameter
// instance, all compared against an arithmetic reference model.
module tb_imm_extend_stage;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  tag;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_imm;
    logic [1:0]  in_mode;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_tag;

    logic        p_in_valid;
    logic        p_in_ready;
    logic [11:0] p_in_imm;
    logic [1:0]  p_in_mode;
    logic [3:0]  p_in_tag;
    logic        p_out_valid;
    logic        p_out_ready;
    logic [31:0] p_out_data;
    logic [3:0]  p_out_tag;

    int vectors;
    int miscompares;
    entry_t sb[$];
    logic [3:0] emitted[$];
    logic last_accept;

    imm_extend_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    imm_extend_stage #(
        .IN_W     (12),
        .OUT_W    (32),
        .BR_SHIFT (2),
        .TAG_W    (4)
    ) dut_wide (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (p_in_valid),
        .in_ready  (p_in_ready),
        .in_imm    (p_in_imm),
        .in_mode   (p_in_mode),
        .in_tag    (p_in_tag),
        .out_valid (p_out_valid),
        .out_ready (p_out_ready),
        .out_data  (p_out_data),
        .out_tag   (p_out_tag)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: treat the immediate as a number and extend arithmetically.
    function automatic logic [63:0] ref_ext(input logic [63:0] imm, input logic [1:0] mode,
                                            input int in_w, input int out_w, input int sh);
        longint val;
        longint uval;
        longint res;
        longint mask;
        uval = longint'(imm);
        val  = imm[in_w-1] ? uval - (64'sd1 <<< in_w) : uval;
        mask = (64'sd1 <<< out_w) - 64'sd1;
        case (mode)
            2'd0:    res = val;
            2'd1:    res = uval;
            2'd2:    res = val * (64'sd1 <<< sh);
            default: res = uval * (64'sd1 <<< (out_w - in_w));
        endcase
        return 64'(res & mask);
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [6:0] imm, input logic [1:0] mode,
                                 input logic [3:0] tag);
        in_valid = v;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
    endtask

    // One clock of checking: compare outputs with the model at the falling
    // edge, update the model for the transfers that the next rising edge
    // performs, then return just after that edge.
    task automatic checkOutput();
        logic   exp_ready;
        logic   exp_valid;
        entry_t e;
        @(negedge clk);
        exp_ready = (sb.size() < 2);
        exp_valid = (sb.size() > 0);
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid) begin
            chk("out_data", 64'(out_data), 64'(sb[0].data));
            chk("out_tag", 64'(out_tag), 64'(sb[0].tag));
        end
        if (exp_valid && out_ready) begin
            emitted.push_back(sb[0].tag);
            void'(sb.pop_front());
        end
        last_accept = in_valid && exp_ready;
        if (last_accept) begin
            e.data = 16'(ref_ext(64'(in_imm), in_mode, 7, 16, 1));
            e.tag  = in_tag;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] sweep_exp[4];
        logic [3:0]  bp_exp[3];
        logic [63:0] wide_exp;
        int budget;
        sweep_exp[0] = 16'hFFC0;
        sweep_exp[1] = 16'h0040;
        sweep_exp[2] = 16'hFF80;
        sweep_exp[3] = 16'h8000;
        bp_exp[0] = 4'd1;
        bp_exp[1] = 4'd2;
        bp_exp[2] = 4'd3;
        vectors = 0;
        miscompares = 0;
        last_accept = 1'b0;

        rst = 1'b1;
        applyStimulus(1'b0, 7'h0, 2'd0, 4'h0);
        out_ready   = 1'b1;
        p_in_valid  = 1'b0;
        p_in_imm    = '0;
        p_in_mode   = 2'd0;
        p_in_tag    = '0;
        p_out_ready = 1'b1;

        #2;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_out_tag", 64'(out_tag), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] mode sweep");
        for (int m = 0; m < 4; m++) begin
            applyStimulus(1'b1, 7'h40, 2'(m), 4'(m + 8));
            checkOutput();
            applyStimulus(1'b0, 7'h0, 2'd0, 4'h0);
            chk("sweep_valid", 64'(out_valid), 64'd1);
            chk("sweep_data", 64'(out_data), 64'(sweep_exp[m]));
            chk("sweep_tag", 64'(out_tag), 64'(m + 8));
            checkOutput();
            checkOutput();
        end

        $display("[TB] sign-extension fill");
        applyStimulus(1'b1, 7'h3F, 2'd0, 4'h5);
        checkOutput();
        applyStimulus(1'b0, 7'h0, 2'd0, 4'h0);
        chk("sext_positive", 64'(out_data), 64'h003F);
        checkOutput();
        applyStimulus(1'b1, 7'h40, 2'd0, 4'h6);
        checkOutput();
        applyStimulus(1'b0, 7'h0, 2'd0, 4'h0);
        chk("sext_bit15", 64'(out_data[15]), 64'd1);
        checkOutput();

        $display("[TB] back-pressure");
        emitted.delete();
        out_ready = 1'b0;
        applyStimulus(1'b1, 7'h11, 2'd1, 4'd1);
        checkOutput();
        applyStimulus(1'b1, 7'h52, 2'd0, 4'd2);
        checkOutput();
        applyStimulus(1'b1, 7'h33, 2'd3, 4'd3);
        checkOutput();
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_c_rejected", 64'(last_accept), 64'd0);
        checkOutput();
        out_ready = 1'b1;
        budget = 0;
        last_accept = 1'b0;
        while (!last_accept && budget < 6) begin
            checkOutput();
            budget++;
        end
        chk("bp_c_accepted", 64'(last_accept), 64'd1);
        applyStimulus(1'b0, 7'h0, 2'd0, 4'h0);
        for (int i = 0; i < 4; i++) checkOutput();
        chk("bp_count", 64'(emitted.size()), 64'd3);
        if (emitted.size() == 3) begin
            for (int i = 0; i < 3; i++) chk("bp_order", 64'(emitted[i]), 64'(bp_exp[i]));
        end

        $display("[TB] streaming");
        emitted.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 7'($urandom), 2'($urandom_range(0, 3)), 4'(i));
            checkOutput();
        end
        applyStimulus(1'b0, 7'h0, 2'd0, 4'h0);
        checkOutput();
        checkOutput();
        chk("stream_count", 64'(emitted.size()), 64'd20);

        $display("[TB] reset mid-operation");
        out_ready = 1'b0;
        applyStimulus(1'b1, 7'h7F, 2'd1, 4'hA);
        checkOutput();
        applyStimulus(1'b1, 7'h01, 2'd3, 4'hB);
        checkOutput();
        applyStimulus(1'b0, 7'h0, 2'd0, 4'h0);
        chk("full_before_reset", 64'(in_ready), 64'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_out_data", 64'(out_data), 64'd0);
        chk("async_out_tag", 64'(out_tag), 64'd0);
        chk("async_in_ready", 64'(in_ready), 64'd1);
        #1;
        rst = 1'b0;
        sb.delete();
        emitted.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) checkOutput();
        chk("no_stale_output", 64'(emitted.size()), 64'd0);
        applyStimulus(1'b1, 7'h2A, 2'd2, 4'hC);
        checkOutput();
        applyStimulus(1'b0, 7'h0, 2'd0, 4'h0);
        checkOutput();
        checkOutput();

        $display("[TB] wide parameter instance");
        for (int i = 0; i < 9; i++) begin
            p_in_valid = 1'b1;
            if (i == 0) begin
                p_in_imm  = 12'h800;
                p_in_mode = 2'd2;
            end else begin
                p_in_imm  = 12'($urandom);
                p_in_mode = 2'($urandom_range(0, 3));
            end
            p_in_tag = 4'(i);
            wide_exp = ref_ext(64'(p_in_imm), p_in_mode, 12, 32, 2);
            @(negedge clk);
            chk("wide_in_ready", 64'(p_in_ready), 64'd1);
            @(posedge clk);
            #1;
            p_in_valid = 1'b0;
            chk("wide_valid", 64'(p_out_valid), 64'd1);
            chk("wide_data", 64'(p_out_data), wide_exp);
            chk("wide_tag", 64'(p_out_tag), 64'(i));
            if (i == 0) chk("wide_branch_800", 64'(p_out_data), 64'hFFFF_E000);
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_imm_extend_stage
